axis_upsizer: RTL and testbench

- Stream width upsizer between the UART byte receive path and the wide matrix-vector datapath.
- Accepts one WORD_W word per handshake on a narrow AXI-stream slave port.
- Packs N_WORDS consecutive words into one BUS_W beat and presents it on an AXI-stream master port.
- Sustains one narrow word per clock while the downstream accepts.

---
 rtl/axis_pkg.sv | 24 ++
 rtl/axis_upsizer_if.sv | 31 +++
 rtl/axis_reg_slice.sv | 39 +++
 rtl/axis_upsizer.sv | 110 +++++++++++
 tb/tb_axis_upsizer.sv | 278 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/axis_pkg.sv
// -----------------------------------------------------------------------------
// axis_pkg
// Shared definitions for the AXI-stream width converters (upsizer, downsizer)
// and their benches.
//   WORD_W     : width of one narrow stream word
//   MAX_WORDS  : largest number of words a converter may pack into one beat
//   word_t     : one narrow word
//   beat_max_t : widest beat; a converter with N_WORDS lanes uses lanes
//                [N_WORDS-1:0] of this shape (lane 0 = first word on the wire)
//   cnt_width  : width of a lane counter for n lanes (never below 1 bit)
// -----------------------------------------------------------------------------
package axis_pkg;

  localparam int WORD_W    = 8;
  localparam int MAX_WORDS = 16;

  typedef logic [WORD_W-1:0] word_t;
  typedef word_t [MAX_WORDS-1:0] beat_max_t;

  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/axis_upsizer_if.sv
// -----------------------------------------------------------------------------
// axis_upsizer_if
// Bundles the narrow input stream and the wide output stream of the upsizer.
//   slave  modport : s_valid, s_data (, s_last) in ; s_ready out
//   master modport : m_valid, m_data (, m_keep, m_last) out ; m_ready in
// Optional feature macro: AXIS_UPSIZER_LAST_EN adds s_last, m_last, m_keep.
// -----------------------------------------------------------------------------
interface axis_upsizer_if #(
  parameter int WORD_W  = axis_pkg::WORD_W,
  parameter int N_WORDS = 4
);

  logic                             s_valid;
  logic                             s_ready;
  logic [WORD_W-1:0]                s_data;
  logic                             m_valid;
  logic                             m_ready;
  logic [N_WORDS-1:0][WORD_W-1:0]   m_data;
`ifdef AXIS_UPSIZER_LAST_EN
  logic                             s_last;
  logic                             m_last;
  logic [N_WORDS-1:0]               m_keep;

  modport slave  (input  s_valid, s_data, s_last, output s_ready);
  modport master (output m_valid, m_data, m_keep, m_last, input m_ready);
`else
  modport slave  (input  s_valid, s_data, output s_ready);
  modport master (output m_valid, m_data, input m_ready);
`endif

endinterface

// File: rtl/axis_reg_slice.sv
// -----------------------------------------------------------------------------
// axis_reg_slice
// One-beat registered stage with valid/ready. A new beat may load on the same
// edge the held beat drains, so a full stream passes with no bubble. The held
// beat and valid stay stable while out_valid && !out_ready.
//   clk, rst        : clock, synchronous active-high reset
//   in_valid/ready  : load side (in_ready = slot free or draining this edge)
//   in_data         : payload to load
//   out_valid/ready : registered output handshake
//   out_data        : registered payload; only changes on load
// -----------------------------------------------------------------------------
module axis_reg_slice #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  assign in_ready = !out_valid || out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (in_valid && in_ready) begin
      out_valid <= 1'b1;
      out_data  <= in_data;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/axis_upsizer.sv
// -----------------------------------------------------------------------------
// axis_upsizer
// Packs N_WORDS consecutive WORD_W words from a narrow AXI stream into one
// wide beat (lane 0 = first word received). Runs at one word per clock while
// the downstream accepts; the completing word is the only one that can stall.
//   clk : clock, all state on posedge
//   rst : synchronous active-high reset, drops partial words and pending beat
//   s   : slave modport  (s_valid, s_ready, s_data [, s_last])
//   m   : master modport (m_valid, m_ready, m_data [, m_keep, m_last])
// Parameters: WORD_W (word width), N_WORDS (1..16 lanes per beat).
// Optional feature macro: AXIS_UPSIZER_LAST_EN -- s_last closes a short beat,
// upper lanes zero-filled, m_keep marks valid lanes, m_last flags that beat.
// -----------------------------------------------------------------------------
module axis_upsizer
  import axis_pkg::*;
#(
  parameter int WORD_W  = axis_pkg::WORD_W,
  parameter int N_WORDS = 4
) (
  input logic            clk,
  input logic            rst,
  axis_upsizer_if.slave  s,
  axis_upsizer_if.master m
);

  localparam int BUS_W = WORD_W * N_WORDS;
  localparam int CNT_W = cnt_width(N_WORDS);
  localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(N_WORDS - 1);
`ifdef AXIS_UPSIZER_LAST_EN
  localparam int PW = BUS_W + N_WORDS + 1;
`else
  localparam int PW = BUS_W;
`endif

  if (N_WORDS < 1 || N_WORDS > MAX_WORDS) begin : g_bad_n_words
    $error("axis_upsizer: N_WORDS=%0d outside 1..%0d", N_WORDS, MAX_WORDS);
  end

  logic [CNT_W-1:0]               cnt;
  logic [N_WORDS-1:0][WORD_W-1:0] asm_q;
  logic [N_WORDS-1:0][WORD_W-1:0] beat;
  logic [N_WORDS-1:0]             keep;
  logic                           completing;
  logic                           s_hs;
  logic                           slice_ready;
  logic [PW-1:0]                  payload;
  logic [PW-1:0]                  out_payload;

`ifdef AXIS_UPSIZER_LAST_EN
  assign completing = (cnt == LAST_LANE) || s.s_last;
`else
  assign completing = (cnt == LAST_LANE);
`endif

  // Only the completing word needs the output slot; earlier words go to asm_q.
  assign s.s_ready = !completing || slice_ready;
  assign s_hs      = s.s_valid && s.s_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt   <= '0;
      asm_q <= '0;
    end else if (s_hs) begin
      if (completing) begin
        cnt <= '0;
      end else begin
        asm_q[cnt] <= s.s_data;
        cnt        <= cnt + 1'b1;
      end
    end
  end

  // Beat as it would load now: stored lanes below cnt, the incoming word in
  // lane cnt, zeros above (only reachable on a short s_last beat).
  always_comb begin
    beat = '0;
    keep = '0;
    for (int i = 0; i < N_WORDS; i++) begin
      if (CNT_W'(i) == cnt) begin
        beat[i] = s.s_data;
        keep[i] = 1'b1;
      end else if (CNT_W'(i) < cnt) begin
        beat[i] = asm_q[i];
        keep[i] = 1'b1;
      end
    end
  end

`ifdef AXIS_UPSIZER_LAST_EN
  assign payload  = {s.s_last, keep, beat};
  assign m.m_data = out_payload[BUS_W-1:0];
  assign m.m_keep = out_payload[BUS_W +: N_WORDS];
  assign m.m_last = out_payload[PW-1];
`else
  assign payload  = beat;
  assign m.m_data = out_payload;
`endif

  axis_reg_slice #(.W(PW)) u_out (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (s_hs && completing),
    .in_ready  (slice_ready),
    .in_data   (payload),
    .out_valid (m.m_valid),
    .out_ready (m.m_ready),
    .out_data  (out_payload)
  );

endmodule

// File: tb/tb_axis_upsizer.sv
// -----------------------------------------------------------------------------
// tb_axis_upsizer
// Bench for axis_upsizer (N_WORDS=4, WORD_W=8). A queue-based model of the
// stream rules runs beside the DUT and is compared on every cycle; directed
// sequences pin literal beats; a random phase checks that the output byte
// stream equals the input byte stream.
// Optional feature macro: AXIS_UPSIZER_LAST_EN enables the s_last cases.
// -----------------------------------------------------------------------------
module tb_axis_upsizer;
  import axis_pkg::*;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int BW = N * W;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  axis_upsizer_if #(.WORD_W(W), .N_WORDS(N)) bus ();

  axis_upsizer #(.WORD_W(W), .N_WORDS(N)) dut (
    .clk (clk),
    .rst (rst),
    .s   (bus),
    .m   (bus)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  word_t          part_q[$];
  word_t          in_stream[$];
  word_t          out_stream[$];
  logic           mdl_valid = 1'b0;
  logic [BW-1:0]  mdl_data  = '0;
  logic [N-1:0]   mdl_keep  = '0;
  logic           mdl_last  = 1'b0;
  bit             live      = 1'b0;
  int             beats_out = 0;

  always @(negedge clk) begin : compare
    logic lst, complete, exp_sr, in_hs, out_hs;
    lst = 1'b0;
`ifdef AXIS_UPSIZER_LAST_EN
    lst = bus.s_last;
`endif
    if (rst) begin
      part_q.delete();
      in_stream.delete();
      out_stream.delete();
      mdl_valid = 1'b0;
      mdl_data  = '0;
      mdl_keep  = '0;
      mdl_last  = 1'b0;
      live      = 1'b1;
    end else if (live) begin
      complete = (part_q.size() == N - 1) || lst;
      exp_sr   = !(complete && mdl_valid && !bus.m_ready);
      chk("s_ready", bus.s_ready, exp_sr);
      chk("m_valid", bus.m_valid, mdl_valid);
      if (mdl_valid) begin
        chk("m_data", bus.m_data, mdl_data);
`ifdef AXIS_UPSIZER_LAST_EN
        chk("m_keep", bus.m_keep, mdl_keep);
        chk("m_last", bus.m_last, mdl_last);
`endif
      end
      in_hs  = bus.s_valid && exp_sr;
      out_hs = mdl_valid && bus.m_ready;
      if (out_hs) begin
        beats_out++;
        for (int i = 0; i < N; i++)
          if (mdl_keep[i]) out_stream.push_back(bus.m_data[i]);
        mdl_valid = 1'b0;
      end
      if (in_hs) begin
        part_q.push_back(bus.s_data);
        in_stream.push_back(bus.s_data);
        if (complete) begin
          mdl_data = '0;
          mdl_keep = '0;
          for (int i = 0; i < part_q.size(); i++) begin
            mdl_data[i*W +: W] = part_q[i];
            mdl_keep[i]        = 1'b1;
          end
          mdl_last  = lst;
          mdl_valid = 1'b1;
          part_q.delete();
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic send(input logic [7:0] b, output int n);
    bit acc;
    acc = 1'b0;
    n   = 0;
    bus.s_valid = 1'b1;
    bus.s_data  = b;
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = bus.s_ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!acc) chk("send_timeout", 64'(n), 64'(0));
    bus.s_valid = 1'b0;
  endtask

`ifdef AXIS_UPSIZER_LAST_EN
  task automatic send_last(input logic [7:0] b, output int n);
    bus.s_last = 1'b1;
    send(b, n);
    bus.s_last = 1'b0;
  endtask
`endif

  task automatic do_reset();
    bus.s_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  // ---------------- main sequence ----------------
  initial begin : main
    int n, total, b0, cyc, mism;
    bit acc;
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    bus.m_ready = 1'b1;
`ifdef AXIS_UPSIZER_LAST_EN
    bus.s_last  = 1'b0;
`endif
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_m_valid", bus.m_valid, 64'(0));
    chk("rst_m_data",  bus.m_data,  64'(0));
    chk("rst_s_ready", bus.s_ready, 64'(1));

    // one beat, latency of exactly one cycle after the completing word
    send(8'h11, n);
    send(8'h22, n);
    send(8'h33, n);
    chk("t1_no_early_valid", bus.m_valid, 64'(0));
    send(8'h44, n);
    chk("t1_m_valid", bus.m_valid, 64'(1));
    chk("t1_m_data",  bus.m_data,  64'h44332211);
    chk("t1_model",   mdl_data,    64'h44332211);
    @(posedge clk);
    #1;
    chk("t1_drained", bus.m_valid, 64'(0));

    // eight back-to-back words, no input stall
    total = 0;
    for (int b = 1; b <= 8; b++) begin
      send(8'(b), n);
      total += n;
      if (b == 4) chk("t2_beat0", bus.m_data, 64'h04030201);
    end
    chk("t2_cycles", 64'(total), 64'(8));
    chk("t2_beat1",  bus.m_data, 64'h08070605);
    chk("t2_valid",  bus.m_valid, 64'(1));
    @(posedge clk);
    #1;

    // back-pressure: completing word waits for the held beat to drain
    do_reset();
    for (int b = 1; b <= 4; b++) send(8'(b), n);
    bus.m_ready = 1'b0;
    total = 0;
    for (int b = 5; b <= 7; b++) begin
      send(8'(b), n);
      total += n;
    end
    chk("t3_accept_5_7", 64'(total), 64'(3));
    bus.s_valid = 1'b1;
    bus.s_data  = 8'h08;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("t3_stall_ready", bus.s_ready, 64'(0));
      chk("t3_held_data",   bus.m_data,  64'h04030201);
      chk("t3_held_valid",  bus.m_valid, 64'(1));
      @(posedge clk);
      #1;
    end
    bus.m_ready = 1'b1;
    @(negedge clk);
    chk("t3_release_ready", bus.s_ready, 64'(1));
    @(posedge clk);
    #1;
    bus.s_valid = 1'b0;
    chk("t3_next_beat",  bus.m_data,  64'h08070605);
    chk("t3_next_valid", bus.m_valid, 64'(1));
    @(posedge clk);
    #1;

    // reset mid-packet leaves no stale lanes
    do_reset();
    send(8'h55, n);
    send(8'h66, n);
    do_reset();
    for (int b = 0; b < 4; b++) send(8'hA0 + 8'(b), n);
    chk("t5_beat", bus.m_data, 64'hA3A2A1A0);
    @(posedge clk);
    #1;

`ifdef AXIS_UPSIZER_LAST_EN
    do_reset();
    send(8'h10, n);
    send_last(8'h20, n);
    chk("t6_data", bus.m_data, 64'h00002010);
    chk("t6_keep", bus.m_keep, 64'(4'b0011));
    chk("t6_last", bus.m_last, 64'(1));
    @(posedge clk);
    #1;
`endif

    // random valid / ready, 100 beats
    do_reset();
    b0  = beats_out;
    cyc = 0;
    acc = 1'b0;
    while ((beats_out - b0) < 100 && cyc < 20000) begin
      if (!(bus.s_valid && !acc)) begin
        bus.s_valid = ($urandom_range(0, 99) < 20);
        bus.s_data  = 8'($urandom);
`ifdef AXIS_UPSIZER_LAST_EN
        bus.s_last  = ($urandom_range(0, 9) == 0);
`endif
      end
      bus.m_ready = ($urandom_range(0, 99) < 20);
      @(negedge clk);
      acc = bus.s_valid && bus.s_ready;
      @(posedge clk);
      #1;
      cyc++;
    end
    chk("rand_beats_done", 64'((beats_out - b0) >= 100), 64'(1));
    bus.s_valid = 1'b0;
`ifdef AXIS_UPSIZER_LAST_EN
    bus.s_last  = 1'b0;
`endif
    bus.m_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("stream_len", 64'(out_stream.size()), 64'(in_stream.size() - part_q.size()));
    mism = 0;
    for (int i = 0; i < out_stream.size() && i < in_stream.size(); i++)
      if (out_stream[i] !== in_stream[i]) mism++;
    chk("stream_data", 64'(mism), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
